skid_pipe: RTL and testbench

Ready-path register slice for the tvalid/tready streaming interface. It is the complement of the data-path slice: it registers the upstream `tready_i` so the downstream ready does not propagate combinationally. A two-entry skid buffer per stage absorbs the in-flight beat. It sits between any two streaming blocks where a ready timing path must be broken, and it can be chained to `STAGES` deep with full throughput.

---
 rtl/skid_pipe.sv | 135 +++++++++++++
 tb/tb_skid_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/skid_pipe.sv
// Ready-path register slice: a chain of two-entry skid stages that registers
// the upstream ready while keeping full throughput; PIPE_EN=0 is a wire-through.
module skid_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter bit PIPE_EN    = 1'b1,
  parameter int STAGES     = 1,
  parameter int CNT_W      = $clog2(2*STAGES+1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] tdata_i,
  input  logic                  tvalid_i,
  output logic                  tready_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_o,
  output logic [CNT_W-1:0]      occ
);

  if (PIPE_EN) begin : g_pipe
    logic [STAGES-1:0]     w_ov;
    logic [STAGES-1:0]     w_rq;
    logic [STAGES-1:0]     w_ov_n;
    logic [STAGES-1:0]     w_sv_n;
    logic [DATA_WIDTH-1:0] w_od [STAGES];
    logic [CNT_W-1:0]      w_occ_n;
    logic [CNT_W-1:0]      r_occ;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic                  r_ov;
      logic                  r_sv;
      logic                  r_rq;
      logic [DATA_WIDTH-1:0] r_od;
      logic [DATA_WIDTH-1:0] r_sd;
      logic                  w_in_valid;
      logic [DATA_WIDTH-1:0] w_in_data;
      logic                  w_out_ready;
      logic                  w_acc;
      logic                  w_drn;
      logic                  w_ov_nx;
      logic                  w_sv_nx;

      if (gi == 0) begin : g_head
        assign w_in_valid = tvalid_i;
        assign w_in_data  = tdata_i;
      end else begin : g_link
        assign w_in_valid = w_ov[gi-1];
        assign w_in_data  = w_od[gi-1];
      end

      // The downstream "ready" of a stage is the registered ready of the next one.
      if (gi == STAGES-1) begin : g_tail
        assign w_out_ready = tready_o;
      end else begin : g_mid
        assign w_out_ready = w_rq[gi+1];
      end

      assign w_acc = w_in_valid & r_rq;
      assign w_drn = r_ov & w_out_ready;

      always_comb begin
        w_ov_nx = r_ov;
        w_sv_nx = r_sv;
        if (!r_ov || w_drn) begin
          if (r_sv) begin
            w_ov_nx = 1'b1;
            w_sv_nx = 1'b0;
          end else begin
            w_ov_nx = w_acc;
          end
        end else if (w_acc) begin
          w_sv_nx = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_ov <= 1'b0;
          r_sv <= 1'b0;
          r_rq <= 1'b0;
          r_od <= '0;
          r_sd <= '0;
        end else begin
          r_ov <= w_ov_nx;
          r_sv <= w_sv_nx;
          r_rq <= ~w_sv_nx;
          if (!r_ov || w_drn) begin
            if (r_sv) begin
              r_od <= r_sd;
            end else if (w_acc) begin
              r_od <= w_in_data;
            end
          end else if (w_acc) begin
            r_sd <= w_in_data;
          end
        end
      end

      assign w_ov[gi]   = r_ov;
      assign w_rq[gi]   = r_rq;
      assign w_od[gi]   = r_od;
      assign w_ov_n[gi] = w_ov_nx;
      assign w_sv_n[gi] = w_sv_nx;
    end

    // Occupancy is built from next-state bits so it stays aligned with the flops.
    always_comb begin
      w_occ_n = '0;
      for (int i = 0; i < STAGES; i++) begin
        w_occ_n = w_occ_n + CNT_W'(w_ov_n[i]) + CNT_W'(w_sv_n[i]);
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_occ <= '0;
      end else begin
        r_occ <= w_occ_n;
      end
    end

    assign tready_i = w_rq[0];
    assign tvalid_o = w_ov[STAGES-1];
    assign tdata_o  = w_od[STAGES-1];
    assign occ      = r_occ;
  end else begin : g_bypass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rstn};
    assign tready_i = tready_o;
    assign tvalid_o = tvalid_i;
    assign tdata_o  = tdata_i;
    assign occ      = '0;
  end

endmodule

// File: tb/tb_skid_pipe.sv
// Directed bench for skid_pipe: one STAGES=1, one STAGES=2 and one bypass
// instance share the stimulus; each step checks the instance it targets.
module tb_skid_pipe;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] tdata_i;
  logic          tvalid_i;
  logic          tready_o;

  logic [DW-1:0] s1_tdata, s2_tdata, b_tdata;
  logic          s1_tvalid, s2_tvalid, b_tvalid;
  logic          s1_tready, s2_tready, b_tready;
  logic [1:0]    s1_occ, b_occ;
  logic [2:0]    s2_occ;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  skid_pipe #(.DATA_WIDTH(DW), .PIPE_EN(1'b1), .STAGES(1)) u_s1 (
    .clk(clk), .rstn(rstn), .tdata_i(tdata_i), .tvalid_i(tvalid_i), .tready_i(s1_tready),
    .tdata_o(s1_tdata), .tvalid_o(s1_tvalid), .tready_o(tready_o), .occ(s1_occ));

  skid_pipe #(.DATA_WIDTH(DW), .PIPE_EN(1'b1), .STAGES(2)) u_s2 (
    .clk(clk), .rstn(rstn), .tdata_i(tdata_i), .tvalid_i(tvalid_i), .tready_i(s2_tready),
    .tdata_o(s2_tdata), .tvalid_o(s2_tvalid), .tready_o(tready_o), .occ(s2_occ));

  skid_pipe #(.DATA_WIDTH(DW), .PIPE_EN(1'b0), .STAGES(1)) u_byp (
    .clk(clk), .rstn(rstn), .tdata_i(tdata_i), .tvalid_i(tvalid_i), .tready_i(b_tready),
    .tdata_o(b_tdata), .tvalid_o(b_tvalid), .tready_o(tready_o), .occ(b_occ));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  // Stall table for STAGES=1: driven ready/valid/data and expected outputs.
  logic          t3_r   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic          t3_v   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [DW-1:0] t3_d   [8] = '{8'h20, 8'h21, 8'h22, 8'h22, 8'h22, 8'h22, 8'h00, 8'h00};
  logic          t3_ev  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [DW-1:0] t3_ed  [8] = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h21, 8'h22, 8'h00};
  logic [1:0]    t3_eo  [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
  logic          t3_er  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  logic          pat    [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  // Bypass vectors: {valid, ready, data}.
  logic          t5_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic          t5_r   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [DW-1:0] t5_d   [4] = '{8'h5A, 8'hA5, 8'h3C, 8'h00};

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] next_d;
    logic [DW-1:0] exp_d;
    int accepted;
    int popped;
    int cyc;
    int max_occ;
    int k_exp_occ;

    // Reset held with valid asserted.
    rstn     = 1'b0;
    tvalid_i = 1'b1;
    tdata_i  = 8'hAA;
    tready_o = 1'b1;
    repeat (3) next_cycle;
    sample;
    check("rst_s1_tvalid_o", 32'(s1_tvalid), 32'd0);
    check("rst_s1_tready_i", 32'(s1_tready), 32'd0);
    check("rst_s1_occ",      32'(s1_occ),    32'd0);
    check("rst_s1_tdata_o",  32'(s1_tdata),  32'd0);
    check("rst_s2_tvalid_o", 32'(s2_tvalid), 32'd0);
    check("rst_s2_tready_i", 32'(s2_tready), 32'd0);
    check("rst_s2_occ",      32'(s2_occ),    32'd0);
    next_cycle;
    rstn     = 1'b1;
    tvalid_i = 1'b0;
    sample;
    check("rel_pre_edge_tready_i", 32'(s2_tready), 32'd0);
    next_cycle;
    sample;
    check("rel_s1_tready_i", 32'(s1_tready), 32'd1);
    check("rel_s2_tready_i", 32'(s2_tready), 32'd1);
    check("rel_s2_tvalid_o", 32'(s2_tvalid), 32'd0);

    // Back-to-back 0x01..0x10 through STAGES=2 with ready held high.
    for (int k = 0; k <= 18; k++) begin
      next_cycle;
      tvalid_i = (k < 16);
      tdata_i  = (k < 16) ? DW'(k + 1) : 8'h00;
      sample;
      if (k == 0)       k_exp_occ = 0;
      else if (k == 1)  k_exp_occ = 1;
      else if (k <= 16) k_exp_occ = 2;
      else if (k == 17) k_exp_occ = 1;
      else              k_exp_occ = 0;
      check($sformatf("stream_tvalid_o[%0d]", k), 32'(s2_tvalid), 32'((k >= 2) && (k <= 17)));
      check($sformatf("stream_occ[%0d]", k), 32'(s2_occ), 32'(k_exp_occ));
      if (k < 16) check($sformatf("stream_tready_i[%0d]", k), 32'(s2_tready), 32'd1);
      if ((k >= 2) && (k <= 17)) check($sformatf("stream_tdata_o[%0d]", k), 32'(s2_tdata), 32'(k - 1));
    end

    // Stall on STAGES=1: ready low for 3 cycles against a continuous source.
    for (int j = 0; j < 8; j++) begin
      next_cycle;
      tready_o = t3_r[j];
      tvalid_i = t3_v[j];
      tdata_i  = t3_d[j];
      sample;
      check($sformatf("stall_tvalid_o[%0d]", j), 32'(s1_tvalid), 32'(t3_ev[j]));
      check($sformatf("stall_occ[%0d]", j),      32'(s1_occ),    32'(t3_eo[j]));
      check($sformatf("stall_tready_i[%0d]", j), 32'(s1_tready), 32'(t3_er[j]));
      if (t3_ev[j]) check($sformatf("stall_tdata_o[%0d]", j), 32'(s1_tdata), 32'(t3_ed[j]));
    end

    // Drain anything the STAGES=2 instance picked up, then random traffic on it.
    tvalid_i = 1'b0;
    tready_o = 1'b1;
    repeat (8) next_cycle;
    sample;
    check("rand_pre_occ", 32'(s2_occ), 32'd0);

    accepted = 0;
    popped   = 0;
    cyc      = 0;
    max_occ  = 0;
    next_d   = 8'h00;
    while ((popped < 1000) && (cyc < 20000)) begin
      next_cycle;
      tready_o = pat[cyc % 7];
      tvalid_i = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      tdata_i  = next_d;
      sample;
      check("rand_occ_vs_model", 32'(s2_occ), 32'(q.size()));
      if (int'(s2_occ) > max_occ) max_occ = int'(s2_occ);
      if (s2_tvalid && tready_o) begin
        check("rand_output_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_d = q.pop_front();
          check("rand_tdata_o", 32'(s2_tdata), 32'(exp_d));
        end
        popped++;
      end
      if (tvalid_i && s2_tready) begin
        q.push_back(next_d);
        next_d = next_d + 8'd1;
        accepted++;
      end
      cyc++;
    end
    check("rand_beats_out", 32'(popped), 32'd1000);
    check("rand_queue_empty", 32'(q.size()), 32'd0);
    check("rand_occ_max_le_4", 32'(max_occ <= 4), 32'd1);

    // Bypass instance: outputs follow inputs combinationally.
    for (int v = 0; v < 4; v++) begin
      next_cycle;
      tvalid_i = t5_v[v];
      tready_o = t5_r[v];
      tdata_i  = t5_d[v];
      sample;
      check($sformatf("byp_tvalid_o[%0d]", v), 32'(b_tvalid), 32'(t5_v[v]));
      check($sformatf("byp_tready_i[%0d]", v), 32'(b_tready), 32'(t5_r[v]));
      check($sformatf("byp_tdata_o[%0d]", v),  32'(b_tdata),  32'(t5_d[v]));
      check($sformatf("byp_occ[%0d]", v),      32'(b_occ),    32'd0);
    end

    // Fill STAGES=2 to occ=4, then reset mid-cycle.
    tready_o = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle;
      tvalid_i = 1'b1;
      tdata_i  = DW'(8'hC0 + i);
      sample;
      if (s2_occ == 3'd4) break;
    end
    check("mid_occ_full", 32'(s2_occ), 32'd4);
    check("mid_full_tready_i", 32'(s2_tready), 32'd0);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_tvalid_o", 32'(s2_tvalid), 32'd0);
    check("mid_rst_occ",      32'(s2_occ),    32'd0);
    check("mid_rst_tready_i", 32'(s2_tready), 32'd0);
    check("mid_rst_tdata_o",  32'(s2_tdata),  32'd0);
    repeat (2) next_cycle;
    rstn     = 1'b1;
    tvalid_i = 1'b0;
    tready_o = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle;
      sample;
      check($sformatf("post_rst_tvalid_o[%0d]", i), 32'(s2_tvalid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
